// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : load_store_unit                                            |
// | Description : RV32 byte-addressed load/store front-end for a word-       |
// |               addressed data memory (sync write, async read). Sub-word   |
// |               stores use read-modify-write; loads are extended; bad      |
// |               funct3 or misaligned requests answer with an error.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module load_store_unit #(
   parameter int P_ADDR_WIDTH = 8,
   parameter int P_XLEN       = 32
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_we,
   input  logic [2:0]              i_req_funct3,
   input  logic [P_XLEN-1:0]       i_req_addr,
   input  logic [P_XLEN-1:0]       i_req_wdata,
   output logic                    o_rsp_valid,
   output logic [P_XLEN-1:0]       o_rsp_rdata,
   output logic                    o_rsp_err,
   output logic                    o_mem_we,
   output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
   output logic [P_XLEN-1:0]       o_mem_wdata,
   input  logic [P_XLEN-1:0]       i_mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_MERGE = 3'd2,
      S_WRITE = 3'd3,
      S_ERR   = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t                  state_q;
   logic [2:0]              funct3_q;
   logic [P_ADDR_WIDTH+1:0] addr_q;       // word address plus byte offset
   logic [15:0]             wdata_q;      // only sub-word stores need the saved data
   logic [P_XLEN-1:0]       mem_wdata_q;
   logic                    rsp_valid_q;
   logic [P_XLEN-1:0]       rsp_rdata_q;
   logic                    rsp_err_q;

   logic                    w_legal;
   logic                    w_misaligned;
   logic                    w_req_err;
   logic [7:0]              w_byte;
   logic [15:0]             w_half;
   logic [P_XLEN-1:0]       load_rdata_d;
   logic [P_XLEN-1:0]       merged_d;

   // Address bits above the memory size are deliberately discarded (wrap-around)
   logic                    w_unused_addr_hi;
   assign w_unused_addr_hi = ^i_req_addr[P_XLEN-1:P_ADDR_WIDTH+2];

   // Classify the incoming request: legal funct3 for its direction, and alignment
   always_comb begin
      w_legal = 1'b0;
      if (i_req_we) begin
         w_legal = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) ||
                   (i_req_funct3 == 3'b010);
      end else begin
         w_legal = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) ||
                   (i_req_funct3 == 3'b010) || (i_req_funct3 == 3'b100) ||
                   (i_req_funct3 == 3'b101);
      end
      w_misaligned = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                     ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
      w_req_err    = !w_legal || w_misaligned;
   end

   // Select the addressed lane of the read word and extend it for the load result
   always_comb begin
      w_byte       = i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      w_half       = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
      load_rdata_d = i_mem_rdata;
      case (funct3_q[1:0])
         2'b00:   load_rdata_d = {{24{w_byte[7] & ~funct3_q[2]}}, w_byte};
         2'b01:   load_rdata_d = {{16{w_half[15] & ~funct3_q[2]}}, w_half};
         default: load_rdata_d = i_mem_rdata;
      endcase
   end

   // Replace the addressed byte/half lanes of the read word with the store data
   always_comb begin
      merged_d = i_mem_rdata;
      if (funct3_q[1:0] == 2'b00) begin
         merged_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end else if (addr_q[1]) begin
         merged_d[31:16] = wdata_q;
      end else begin
         merged_d[15:0]  = wdata_q;
      end
   end

   // Request sequencer: accept, access memory, then present a one-cycle response
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         funct3_q    <= 3'b000;
         addr_q      <= '0;
         wdata_q     <= 16'h0000;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_req_valid) begin
                  funct3_q <= i_req_funct3;
                  addr_q   <= i_req_addr[P_ADDR_WIDTH+1:0];
                  wdata_q  <= i_req_wdata[15:0];
                  if (w_req_err) begin
                     state_q <= S_ERR;
                  end else if (!i_req_we) begin
                     state_q <= S_LOAD;
                  end else if (i_req_funct3[1:0] == 2'b10) begin
                     mem_wdata_q <= i_req_wdata;
                     state_q     <= S_WRITE;
                  end else begin
                     state_q <= S_MERGE;
                  end
               end
            end
            S_LOAD: begin
               rsp_rdata_q <= load_rdata_d;
               rsp_err_q   <= 1'b0;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_MERGE: begin
               mem_wdata_q <= merged_d;
               state_q     <= S_WRITE;
            end
            S_WRITE: begin
               rsp_rdata_q <= '0;
               rsp_err_q   <= 1'b0;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_ERR: begin
               rsp_rdata_q <= '0;
               rsp_err_q   <= 1'b1;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign o_req_ready = (state_q == S_IDLE);
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_err   = rsp_err_q;
   // Gated by reset so that a reset edge never coincides with a memory write
   assign o_mem_we    = (state_q == S_WRITE) && i_rst_n;
   assign o_mem_addr  = addr_q[P_ADDR_WIDTH+1:2];
   assign o_mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_load_store_unit                                         |
// | Description : Directed, table-driven bench for load_store_unit with a    |
// |               behavioural 256-word data memory.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:255];
   logic        pre_we = 1'b0;
   logic [7:0]  pre_idx = 8'h00;
   logic [31:0] pre_val = 32'h0;

   int n_cmp  = 0;
   int n_fail = 0;
   int wr_cnt = 0;
   int acc_cnt = 0;
   int rsp_cnt = 0;

   always #5 clk = ~clk;

   load_store_unit #(.P_ADDR_WIDTH(8), .P_XLEN(32)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_we     (req_we),
      .i_req_funct3 (req_funct3),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_rdata  (rsp_rdata),
      .o_rsp_err    (rsp_err),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .i_mem_rdata  (mem_rdata)
   );

   // Data memory: synchronous write (bench preload has priority), async read
   always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_val;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr];

   // Event counters for writes, accepts and responses
   always @(posedge clk) begin
      if (mem_we) wr_cnt <= wr_cnt + 1;
      if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
   end
   always @(negedge clk) begin
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
   end

   typedef struct {
      string       name;
      logic        pre;
      logic [7:0]  pidx;
      logic [31:0] pval;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      int          exp_wr;
      logic [7:0]  cidx;
      logic [31:0] cval;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic pre, input logic [7:0] pidx,
                      input logic [31:0] pval, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                      input int exp_wr, input logic [7:0] cidx, input logic [31:0] cval);
      vec_t t;
      t.name = name; t.pre = pre; t.pidx = pidx; t.pval = pval; t.we = we; t.f3 = f3;
      t.addr = addr; t.wdata = wdata; t.exp_rd = exp_rd; t.exp_err = exp_err;
      t.exp_lat = exp_lat; t.exp_wr = exp_wr; t.cidx = cidx; t.cval = cval;
      vecs.push_back(t);
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] val);
      @(negedge clk);
      pre_we = 1'b1; pre_idx = idx; pre_val = val;
      @(posedge clk);
      #1 pre_we = 1'b0;
   endtask

   task automatic run_vec(input vec_t t);
      int          w0;
      int          lat;
      logic [31:0] got_rd;
      logic        got_err;
      if (t.pre) preload(t.pidx, t.pval);
      w0 = wr_cnt;
      @(negedge clk);
      check({t.name, "/ready"}, {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = t.we; req_funct3 = t.f3;
      req_addr = t.addr; req_wdata = t.wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; got_rd = 32'h0; got_err = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = c; got_rd = rsp_rdata; got_err = rsp_err;
            break;
         end
      end
      check({t.name, "/latency"}, lat, t.exp_lat);
      check({t.name, "/rdata"}, got_rd, t.exp_rd);
      check({t.name, "/err"}, {31'b0, got_err}, {31'b0, t.exp_err});
      @(negedge clk);
      check({t.name, "/pulse"}, {31'b0, rsp_valid}, 32'd0);
      check({t.name, "/writes"}, wr_cnt - w0, t.exp_wr);
      check({t.name, "/memword"}, mem[t.cidx], t.cval);
   endtask

   initial begin
      int w0, r0, a0;

      // name pre idx val we f3 addr wdata exp_rd err lat wr cidx cval
      add("SW_10",   0, 8'd0, 32'h0,        1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2, 1, 8'd4, 32'hDEADBEEF);
      add("LW_10",   0, 8'd0, 32'h0,        0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2, 0, 8'd4, 32'hDEADBEEF);
      add("SB_13",   1, 8'd4, 32'h11223344, 1, 3'b000, 32'h13,  32'hAA,       32'h0,        0, 3, 1, 8'd4, 32'hAA223344);
      add("LB_13",   0, 8'd0, 32'h0,        0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFAA, 0, 2, 0, 8'd4, 32'hAA223344);
      add("LBU_13",  0, 8'd0, 32'h0,        0, 3'b100, 32'h13,  32'h0,        32'h000000AA, 0, 2, 0, 8'd4, 32'hAA223344);
      add("LB_10",   0, 8'd0, 32'h0,        0, 3'b000, 32'h10,  32'h0,        32'h00000044, 0, 2, 0, 8'd4, 32'hAA223344);
      add("SH_12",   1, 8'd4, 32'h11223344, 1, 3'b001, 32'h12,  32'h8001,     32'h0,        0, 3, 1, 8'd4, 32'h80013344);
      add("LH_12",   0, 8'd0, 32'h0,        0, 3'b001, 32'h12,  32'h0,        32'hFFFF8001, 0, 2, 0, 8'd4, 32'h80013344);
      add("LHU_12",  0, 8'd0, 32'h0,        0, 3'b101, 32'h12,  32'h0,        32'h00008001, 0, 2, 0, 8'd4, 32'h80013344);
      add("LH_10",   0, 8'd0, 32'h0,        0, 3'b001, 32'h10,  32'h0,        32'h00003344, 0, 2, 0, 8'd4, 32'h80013344);
      add("LB_11",   0, 8'd0, 32'h0,        0, 3'b000, 32'h11,  32'h0,        32'h00000033, 0, 2, 0, 8'd4, 32'h80013344);
      add("LW_11",   0, 8'd0, 32'h0,        0, 3'b010, 32'h11,  32'h0,        32'h0,        1, 2, 0, 8'd4, 32'h80013344);
      add("SH_13",   0, 8'd0, 32'h0,        1, 3'b001, 32'h13,  32'hFFFF,     32'h0,        1, 2, 0, 8'd4, 32'h80013344);
      add("LD_F011", 0, 8'd0, 32'h0,        0, 3'b011, 32'h10,  32'h0,        32'h0,        1, 2, 0, 8'd4, 32'h80013344);
      add("ST_F100", 0, 8'd0, 32'h0,        1, 3'b100, 32'h10,  32'h12345678, 32'h0,        1, 2, 0, 8'd4, 32'h80013344);
      add("ST_F111", 0, 8'd0, 32'h0,        1, 3'b111, 32'h10,  32'h12345678, 32'h0,        1, 2, 0, 8'd4, 32'h80013344);
      add("LHU_11",  0, 8'd0, 32'h0,        0, 3'b101, 32'h11,  32'h0,        32'h0,        1, 2, 0, 8'd4, 32'h80013344);
      add("SB_10",   0, 8'd0, 32'h0,        1, 3'b000, 32'h10,  32'h1FF,      32'h0,        0, 3, 1, 8'd4, 32'h800133FF);
      add("SH_10",   0, 8'd0, 32'h0,        1, 3'b001, 32'h10,  32'hABCD1234, 32'h0,        0, 3, 1, 8'd4, 32'h80011234);
      add("SW_400",  1, 8'd0, 32'h12345678, 1, 3'b010, 32'h400, 32'h5,        32'h0,        0, 2, 1, 8'd0, 32'h00000005);
      add("LW_400",  0, 8'd0, 32'h0,        0, 3'b010, 32'h400, 32'h0,        32'h00000005, 0, 2, 0, 8'd0, 32'h00000005);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst/ready", {31'b0, req_ready}, 32'd1);
      check("rst/valid", {31'b0, rsp_valid}, 32'd0);
      check("rst/rdata", rsp_rdata, 32'h0);
      check("rst/err", {31'b0, rsp_err}, 32'd0);
      check("rst/mem_we", {31'b0, mem_we}, 32'd0);
      check("rst/mem_addr", {24'b0, mem_addr}, 32'h0);
      check("rst/mem_wdata", mem_wdata, 32'h0);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset asserted during the MERGE cycle of an SB: nothing may be written
      preload(8'd4, 32'h11223344);
      w0 = wr_cnt; r0 = rsp_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h13; req_wdata = 32'hAA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("rstmid/writes", wr_cnt - w0, 0);
      check("rstmid/rsp", rsp_cnt - r0, 0);
      check("rstmid/word", mem[4], 32'h11223344);
      check("rstmid/ready", {31'b0, req_ready}, 32'd1);

      // Held request: 5 cycles of valid covers two full SW transactions
      preload(8'd1, 32'h0);
      w0 = wr_cnt; r0 = rsp_cnt; a0 = acc_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h404; req_wdata = 32'h77;
      repeat (5) @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("hold/accepts", acc_cnt - a0, 2);
      check("hold/writes", wr_cnt - w0, 2);
      check("hold/rsp", rsp_cnt - r0, 2);
      check("hold/word", mem[1], 32'h77);
      check("hold/ready", {31'b0, req_ready}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
